// File: rtl/uart_recv.sv
// 8N1 UART receiver: double-flop synchroniser, start-edge detect and mid-bit
// sampling off a single bit-period counter; one-cycle valid / frame_err pulses.
module uart_recv #(
    parameter int CNT_MAX = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF  = CNT_MAX / 2;
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;
    logic             busy_reg, busy_next;
    logic             din_meta_reg, din_s_reg, din_d_reg;

    logic fall;
    logic cnt_end;
    logic bit_sample;

    assign fall       = din_d_reg & ~din_s_reg;
    assign cnt_end    = (cnt_reg == CNT_LAST);
    assign bit_sample = (state_reg == DATA) && cnt_end;

    // Each shift bit only loads when its own index is the one being sampled.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (bit_sample && (idx_reg == 3'(gi))) ? din_s_reg
                                                                         : shift_reg[gi];
        end
    endgenerate

    // State and datapath registers; synchroniser resets to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta_reg <= 1'b1;
            din_s_reg    <= 1'b1;
            din_d_reg    <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            din_meta_reg <= din;
            din_s_reg    <= din_meta_reg;
            din_d_reg    <= din_s_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (fall) state_next = START;
            START: if (cnt_reg == HALF_LAST) state_next = din_s_reg ? IDLE : DATA;
            DATA:  if (cnt_end && (idx_reg == 3'd7)) state_next = STOP;
            STOP:  if (cnt_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        busy_next  = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                idx_next = '0;
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    idx_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_end) begin
                    cnt_next = '0;
                    idx_next = idx_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_end) begin
                    cnt_next = '0;
                    if (din_s_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                cnt_next = '0;
                idx_next = '0;
            end
        endcase
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = ferr_reg;
    assign busy      = busy_reg;

endmodule
